// File: rtl/cnn_layer_sequencer.sv
// Control sequencer for a four-stage CNN layer pipeline followed by a serial ten-way argmax.
// Define CNN_SEQ_TIMEOUT_EN to add a per-stage watchdog that can drive the FSM into ERROR.
module cnn_layer_sequencer #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         conv_done,
    input  logic         relu_done,
    input  logic         pool_done,
    input  logic         fc_done,
    input  logic [319:0] prob_flat,
    output logic         conv_enable,
    output logic         relu_enable,
    output logic         pool_enable,
    output logic         fc_enable,
    output logic         busy,
    output logic [2:0]   stage,
    output logic [3:0]   result,
    output logic         result_valid,
    output logic         error
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CONV   = 3'd1,
        S_RELU   = 3'd2,
        S_POOL   = 3'd3,
        S_FC     = 3'd4,
        S_ARGMAX = 3'd5,
        S_DONE   = 3'd6,
        S_ERROR  = 3'd7
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'd9;

    state_t            state;
    state_t            state_next;
    logic [3:0]        arg_idx;
    logic [9:0][31:0]  prob_p0;
    logic [31:0]       best_val_p1;
    logic [3:0]        best_idx_p1;
    logic              cand_gt;
    logic [3:0]        cand_idx;
    logic              in_stage;
    logic              start_ok;
    logic              capture;
    logic              timeout_hit;

    // Strictly-greater unsigned compare: ties keep the earlier (lower) index.
    function automatic logic score_gt(input logic [31:0] a, input logic [31:0] b);
        return a > b;
    endfunction

    assign in_stage = (state == S_CONV) || (state == S_RELU) ||
                      (state == S_POOL) || (state == S_FC);
    assign busy     = !((state == S_IDLE) || (state == S_DONE) || (state == S_ERROR));
    assign start_ok = start && !busy;
    assign capture  = (state == S_FC) && fc_done;
    assign cand_gt  = score_gt(prob_p0[arg_idx], best_val_p1);
    assign cand_idx = cand_gt ? arg_idx : best_idx_p1;

`ifdef CNN_SEQ_TIMEOUT_EN
    localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] stage_cnt;

    assign timeout_hit = in_stage && (stage_cnt == TO_LIMIT);

    // Counter restarts on every state change so each stage gets its own budget.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_cnt <= 16'd0;
            error     <= 1'b0;
        end else begin
            if (state_next != state) begin
                stage_cnt <= 16'd0;
            end else if (in_stage) begin
                stage_cnt <= stage_cnt + 16'd1;
            end
            if ((state_next == S_ERROR) && (state != S_ERROR)) begin
                error <= 1'b1;
            end else if (start_ok) begin
                error <= 1'b0;
            end
        end
    end
`else
    logic unused_cfg;

    assign unused_cfg  = |16'(TIMEOUT_CYCLES);
    assign timeout_hit = 1'b0;
    assign error       = 1'b0;
`endif

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) state_next = S_CONV;
            end
            S_CONV: begin
                if (conv_done)        state_next = S_RELU;
                else if (timeout_hit) state_next = S_ERROR;
            end
            S_RELU: begin
                if (relu_done)        state_next = S_POOL;
                else if (timeout_hit) state_next = S_ERROR;
            end
            S_POOL: begin
                if (pool_done)        state_next = S_FC;
                else if (timeout_hit) state_next = S_ERROR;
            end
            S_FC: begin
                if (fc_done)          state_next = S_ARGMAX;
                else if (timeout_hit) state_next = S_ERROR;
            end
            S_ARGMAX: begin
                if (arg_idx == LAST_IDX) state_next = S_DONE;
            end
            S_DONE: begin
                state_next = start ? S_CONV : S_IDLE;
            end
            S_ERROR: begin
                if (start) state_next = S_CONV;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        conv_enable  = (state == S_CONV);
        relu_enable  = (state == S_RELU);
        pool_enable  = (state == S_POOL);
        fc_enable    = (state == S_FC);
        result_valid = (state == S_DONE);
        stage        = state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            arg_idx <= 4'd0;
            result  <= 4'hF;
        end else begin
            state <= state_next;
            if (capture) begin
                arg_idx <= 4'd1;
            end else if ((state == S_ARGMAX) && (arg_idx != LAST_IDX)) begin
                arg_idx <= arg_idx + 4'd1;
            end
            // Final compare folds straight into result so DONE sees the winner.
            if ((state == S_ARGMAX) && (arg_idx == LAST_IDX)) begin
                result <= cand_idx;
            end
        end
    end

    // p0: score capture on fc_done; p1: running best, one index per ARGMAX cycle
    always_ff @(posedge clk) begin
        if (capture) begin
            prob_p0     <= prob_flat;
            best_val_p1 <= prob_flat[31:0];
            best_idx_p1 <= 4'd0;
        end else if ((state == S_ARGMAX) && cand_gt) begin
            best_val_p1 <= prob_p0[arg_idx];
            best_idx_p1 <= arg_idx;
        end
    end

endmodule
